uart_tx_fifo: RTL

- Buffered byte-queue front end placed directly upstream of uart_tx.
- Accepts bytes from a producer on a single-cycle write strobe and stores them in a circular FIFO.
- Drains them one at a time into uart_tx using uart_tx's tx_start/tx_data/tx_busy handshake, so producers never poll tx_busy.
- Flags overflow and a missing start acknowledge from the transmitter.

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: buffers producer writes and launches them one at a
// time through the tx_start/tx_data/tx_busy handshake, flagging overflow and start timeouts.
module uart_tx_fifo #(
   parameter  int DEPTH         = 16,
   parameter  int START_TIMEOUT = 4,
   localparam int CW            = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          overflow,
   output logic          start_err,
   output logic          drained,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   input  logic          tx_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_LAST   = TW'(START_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_next;
   logic          push;
   logic          pop;
   logic          timeout_hit;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == {CW{1'b0}});
   assign drained = empty && (state == IDLE) && !tx_busy;

   // Launch sequencing: pop only when idle with data and a quiet transmitter.
   always_comb begin
      state_next  = state;
      timer_next  = timer;
      pop         = 1'b0;
      timeout_hit = 1'b0;
      push        = wr_en && !full;
      case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               pop        = 1'b1;
               state_next = WAIT_BUSY;
               timer_next = {TW{1'b0}};
            end else begin
               state_next = IDLE;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_next = WAIT_DONE;
               timer_next = {TW{1'b0}};
            end else if (timer == TMO_LAST) begin
               timeout_hit = 1'b1;
               state_next  = IDLE;
               timer_next  = {TW{1'b0}};
            end else begin
               timer_next = timer + TW'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_next = IDLE;
            end else begin
               state_next = WAIT_DONE;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = {TW{1'b0}};
         end
      endcase
   end

   // FSM state and start-timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         timer <= {TW{1'b0}};
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   // Storage array has no reset; only occupied slots are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; a write while full is dropped even if a pop happens.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         count  <= {CW{1'b0}};
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Transmitter interface: tx_data only moves on a pop, tx_start is a one-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         tx_start <= pop;
         if (pop) begin
            tx_data <= mem[rd_ptr];
         end
      end
   end

   // Sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         start_err <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (timeout_hit) begin
            start_err <= 1'b1;
         end
      end
   end

endmodule
